// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS/IDCODE data
// registers, instruction decode and a falling-edge TDO mux toward the pins.
module jtag_tap_ir #(
    parameter int                     IR_WIDTH   = 4,
    parameter logic [31:0]            IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]    OP_EXTEST  = {IR_WIDTH{1'b0}},
    parameter logic [IR_WIDTH-1:0]    OP_SAMPLE  = IR_WIDTH'(1'b1),
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE  = IR_WIDTH'(2'b10),
    parameter logic [IR_WIDTH-1:0]    OP_BYPASS  = {IR_WIDTH{1'b1}}
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                TDO,
    output logic                tdo_en,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] instr,
    output logic                clockdr,
    output logic                shiftdr,
    output logic                updatedr,
    output logic                clockir,
    output logic                shiftir,
    output logic                updateir,
    output logic                select,
    output logic                bs_en
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_e            state_r;
    tap_state_e            state_nxt_s;
    logic [IR_WIDTH-1:0]   ir_sr_r;
    logic [IR_WIDTH-1:0]   instr_r;
    logic [31:0]           idcode_r;
    logic                  bypass_r;
    logic                  tdo_r;
    logic                  tdo_en_r;
    logic                  tdo_nxt_s;
    logic                  tdo_en_nxt_s;
    logic                  sel_bsr_s;
    logic                  sel_idcode_s;
    logic                  ir_side_s;

    // TAP state register, advanced by TMS on the rising edge
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // IEEE 1149.1 next-state function
    always_comb begin
        state_nxt_s = ST_TLR;
        case (state_r)
            ST_TLR:      state_nxt_s = TMS ? ST_TLR      : ST_RTI;
            ST_RTI:      state_nxt_s = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_nxt_s = TMS ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_nxt_s = TMS ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    state_nxt_s = TMS ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   state_nxt_s = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_nxt_s = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   state_nxt_s = TMS ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   state_nxt_s = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_nxt_s = TMS ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_nxt_s = TMS ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    state_nxt_s = TMS ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   state_nxt_s = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_nxt_s = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   state_nxt_s = TMS ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   state_nxt_s = TMS ? ST_SEL_DR   : ST_RTI;
            default:     state_nxt_s = ST_TLR;
        endcase
    end

    // Instruction decode; undefined opcodes fall through to BYPASS
    always_comb begin
        sel_bsr_s    = 1'b0;
        sel_idcode_s = 1'b0;
        if ((instr_r == OP_EXTEST) || (instr_r == OP_SAMPLE)) begin
            sel_bsr_s = 1'b1;
        end else if (instr_r == OP_IDCODE) begin
            sel_idcode_s = 1'b1;
        end else begin
            sel_bsr_s    = 1'b0;
            sel_idcode_s = 1'b0;
        end
    end

    // IR shift register: capture 0..01, shift TDI in at the MSB
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_r <= IR_CAPTURE;
        end else if (state_r == ST_CAP_IR) begin
            ir_sr_r <= IR_CAPTURE;
        end else if (state_r == ST_SH_IR) begin
            ir_sr_r <= {TDI, ir_sr_r[IR_WIDTH-1:1]};
        end else begin
            ir_sr_r <= ir_sr_r;
        end
    end

    // IDCODE data register, only active while IDCODE is the instruction
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            idcode_r <= IDCODE_VAL;
        end else if (sel_idcode_s && (state_r == ST_CAP_DR)) begin
            idcode_r <= IDCODE_VAL;
        end else if (sel_idcode_s && (state_r == ST_SH_DR)) begin
            idcode_r <= {TDI, idcode_r[31:1]};
        end else begin
            idcode_r <= idcode_r;
        end
    end

    // Single-bit bypass register for BYPASS and unknown opcodes
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_r <= 1'b0;
        end else if (!sel_bsr_s && !sel_idcode_s && (state_r == ST_CAP_DR)) begin
            bypass_r <= 1'b0;
        end else if (!sel_bsr_s && !sel_idcode_s && (state_r == ST_SH_DR)) begin
            bypass_r <= TDI;
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // TDO source selection for the next falling edge
    always_comb begin
        tdo_nxt_s    = 1'b0;
        tdo_en_nxt_s = 1'b0;
        if (state_r == ST_SH_IR) begin
            tdo_nxt_s    = ir_sr_r[0];
            tdo_en_nxt_s = 1'b1;
        end else if (state_r == ST_SH_DR) begin
            tdo_en_nxt_s = 1'b1;
            if (sel_bsr_s) begin
                tdo_nxt_s = bsr_tdo;
            end else if (sel_idcode_s) begin
                tdo_nxt_s = idcode_r[0];
            end else begin
                tdo_nxt_s = bypass_r;
            end
        end else begin
            tdo_nxt_s    = 1'b0;
            tdo_en_nxt_s = 1'b0;
        end
    end

    // Falling-edge TDO driver so data is stable around the next rising edge
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_r    <= 1'b0;
            tdo_en_r <= 1'b0;
        end else begin
            tdo_r    <= tdo_nxt_s;
            tdo_en_r <= tdo_en_nxt_s;
        end
    end

    // Active instruction; changes only on the fall in Update-IR or TLR
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            instr_r <= OP_IDCODE;
        end else if (state_r == ST_UPD_IR) begin
            instr_r <= ir_sr_r;
        end else if (state_r == ST_TLR) begin
            instr_r <= OP_IDCODE;
        end else begin
            instr_r <= instr_r;
        end
    end

    // IR-side state membership for the select output
    always_comb begin
        ir_side_s = 1'b0;
        case (state_r)
            ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
            ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR: ir_side_s = 1'b1;
            default:                          ir_side_s = 1'b0;
        endcase
    end

    assign state    = state_r;
    assign instr    = instr_r;
    assign TDO      = tdo_r;
    assign tdo_en   = tdo_en_r;
    assign clockdr  = (state_r == ST_CAP_DR) || (state_r == ST_SH_DR);
    assign shiftdr  = (state_r == ST_SH_DR);
    assign updatedr = (state_r == ST_UPD_DR);
    assign clockir  = (state_r == ST_CAP_IR) || (state_r == ST_SH_IR);
    assign shiftir  = (state_r == ST_SH_IR);
    assign updateir = (state_r == ST_UPD_IR);
    assign select   = ir_side_s;
    assign bs_en    = (instr_r == OP_EXTEST);

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Self-checking bench for jtag_tap_ir: table vectors, directed sequences and
// randomized TMS/TDI traffic against a table-based reference model.
module tb_jtag_tap_ir;

    localparam int          W      = 4;
    localparam logic [31:0] IDVAL  = 32'h1000_0001;

    logic         TCK;
    logic         TRST;
    logic         TMS;
    logic         TDI;
    logic         bsr_tdo;
    logic         TDO;
    logic         tdo_en;
    logic [3:0]   state;
    logic [W-1:0] instr;
    logic         clockdr, shiftdr, updatedr;
    logic         clockir, shiftir, updateir;
    logic         select, bs_en;

    jtag_tap_ir #(.IR_WIDTH(W), .IDCODE_VAL(IDVAL)) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
        .TDO(TDO), .tdo_en(tdo_en), .state(state), .instr(instr),
        .clockdr(clockdr), .shiftdr(shiftdr), .updatedr(updatedr),
        .clockir(clockir), .shiftir(shiftir), .updateir(updateir),
        .select(select), .bs_en(bs_en)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    int errors = 0;
    int checks = 0;

    // Reference model: IEEE transition table indexed by state code
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
    int           ms;
    logic [W-1:0] m_ir, m_instr;
    logic [31:0]  m_id;
    logic         m_byp, m_tdo, m_en;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic       tdo;
        logic       en;
        logic [3:0] ins;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dr_sel(input logic [W-1:0] op);
        if (op == 4'd0 || op == 4'd1) return 0;
        if (op == 4'd2) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        ms = 15; m_instr = 4'd2; m_ir = 4'd1; m_id = IDVAL;
        m_byp = 1'b0; m_tdo = 1'b0; m_en = 1'b0;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(ms));
        chk("instr", 32'(instr), 32'(m_instr));
        chk("tdo", 32'(TDO), 32'(m_tdo));
        chk("tdo_en", 32'(tdo_en), 32'(m_en));
        chk("clockdr", 32'(clockdr), 32'(ms == 6 || ms == 2));
        chk("shiftdr", 32'(shiftdr), 32'(ms == 2));
        chk("updatedr", 32'(updatedr), 32'(ms == 5));
        chk("clockir", 32'(clockir), 32'(ms == 14 || ms == 10));
        chk("shiftir", 32'(shiftir), 32'(ms == 10));
        chk("updateir", 32'(updateir), 32'(ms == 13));
        chk("select", 32'(select), 32'(ms == 4 || ms == 14 || ms == 10 || ms == 9 ||
                                       ms == 11 || ms == 8 || ms == 13));
        chk("bs_en", 32'(bs_en), 32'(m_instr == 4'd0));
    endtask

    task automatic step(input logic tms_v, input logic tdi_v, input logic bsr_v);
        int s;
        TMS = tms_v; TDI = tdi_v; bsr_tdo = bsr_v;
        @(posedge TCK);
        s = dr_sel(m_instr);
        if (ms == 14) m_ir = 4'd1;
        else if (ms == 10) m_ir = (m_ir >> 1) | (4'(tdi_v) << (W - 1));
        if (ms == 6 && s == 1) m_id = IDVAL;
        else if (ms == 2 && s == 1) m_id = (m_id >> 1) | (32'(tdi_v) << 31);
        if (ms == 6 && s == 2) m_byp = 1'b0;
        else if (ms == 2 && s == 2) m_byp = tdi_v;
        ms = tms_v ? nxt1[ms] : nxt0[ms];
        @(negedge TCK);
        s = dr_sel(m_instr);
        m_en = (ms == 10 || ms == 2);
        if (ms == 10) m_tdo = m_ir[0];
        else if (ms == 2) m_tdo = (s == 0) ? bsr_v : (s == 1) ? m_id[0] : m_byp;
        else m_tdo = 1'b0;
        if (ms == 13) m_instr = m_ir;
        else if (ms == 15) m_instr = 4'd2;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge TCK);
        #1 TRST = 1'b0; TMS = 1'b1;
        #2 model_reset();
        check_all();
        TRST = 1'b1;
        #1;
    endtask

    task automatic load_ir(input logic [W-1:0] v);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) step(i == W - 1, v[i], 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("ir_loaded", 32'(instr), 32'(v));
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rec;
        logic [8:0]  brec;
        logic        b;
        logic [7:0]  pat;
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
        model_reset();
        tbl[0]  = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'h2};
        tbl[1]  = '{1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 4'h2};
        tbl[2]  = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 4'h2};
        tbl[3]  = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 4'h2};
        tbl[4]  = '{1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 4'h2};
        tbl[5]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'h2};
        tbl[6]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'h2};
        tbl[7]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'h2};
        tbl[8]  = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 4'h2};
        tbl[9]  = '{1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 4'hF};
        tbl[10] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'hF};

        do_reset();
        step(1'b1, 1'b0, 1'b0);
        chk("rst_state", 32'(state), 32'hF);
        chk("rst_instr", 32'(instr), 32'h2);

        // Table: load BYPASS through IR, TDO shows captured 0001 LSB first
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].tms, tbl[i].tdi, 1'b0);
            chk("tbl_state", 32'(state), 32'(tbl[i].st));
            chk("tbl_tdo", 32'(TDO), 32'(tbl[i].tdo));
            chk("tbl_tdo_en", 32'(tdo_en), 32'(tbl[i].en));
            chk("tbl_instr", 32'(instr), 32'(tbl[i].ins));
        end

        // BYPASS: A5 comes back delayed by one cycle behind a leading 0
        pat = 8'hA5;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        brec[0] = TDO;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, pat[i], 1'b0);
            brec[i + 1] = TDO;
        end
        chk("bypass_stream", 32'(brec), 32'({8'hA5, 1'b0}));
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // IDCODE stream after reset
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rec[0] = TDO;
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            rec[i] = TDO;
        end
        chk("idcode_stream", rec, IDVAL);
        step(1'b1, 1'b0, 1'b0);

        // PauseIR then five TMS=1 clocks back to TLR
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pause_ir", 32'(state), 32'hB);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("tlr_state", 32'(state), 32'hF);
        chk("tlr_instr", 32'(instr), 32'h2);

        // EXTEST: bs_en high, TDO follows bsr_tdo, then SAMPLE clears bs_en
        load_ir(4'd0);
        chk("extest_bs_en", 32'(bs_en), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("capdr_clockdr", 32'(clockdr), 32'd1);
        for (int i = 0; i < 6; i++) begin
            b = 1'($urandom_range(0, 1));
            step(1'b0, 1'b0, b);
            chk("extest_tdo", 32'(TDO), 32'(b));
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        load_ir(4'd1);
        chk("sample_bs_en", 32'(bs_en), 32'd0);

        // Random traffic with occasional IR loads and resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else if ($urandom_range(0, 99) == 0) load_ir(4'($urandom_range(0, 15)));
            step(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ir.md
# jtag_tap_ir

Parametrised IEEE 1149.1 TAP controller with integrated instruction register, BYPASS and IDCODE data registers, and TDO mux. Next generation of the bare TAP state machine: adds TDI/TDO, configurable IR width and opcodes, instruction decode, and an external boundary-scan chain port. Sits between the chip JTAG pins and the boundary-scan cell chain.

## Interface
- IR_WIDTH, 4, instruction register width (≥2)
- IDCODE_VAL, 32'h1000_0001, IDCODE contents; bit 0 must be 1
- OP_EXTEST, 4'b0000, EXTEST opcode
- OP_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode
- OP_IDCODE, 4'b0010, IDCODE opcode; IR reset value
- OP_BYPASS, all ones, BYPASS opcode
- Opcode parameters are IR_WIDTH bits wide.

- TCK  in  1  test clock; the only clock
- TRST  in  1  asynchronous, active-low reset
- TMS  in  1  mode select, sampled on TCK rise
- TDI  in  1  serial data in, sampled on TCK rise
- bsr_tdo  in  1  serial out of external boundary-scan chain
- TDO  out  1  serial data out, changes on TCK fall
- tdo_en  out  1  TDO output-enable
- state  out  4  current TAP state (encoding below)
- instr  out  IR_WIDTH  active instruction
- clockdr  out  1  DR capture/shift enable for BSR cells
- shiftdr  out  1  state == Shift-DR
- updatedr  out  1  state == Update-DR
- clockir, shiftir, updateir  out  1 each  IR-side equivalents
- select  out  1  1 = IR path selected (IR-side states)
- bs_en  out  1  boundary-scan cells drive pins (EXTEST active)

## Operation
- 16-state FSM, encodings: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions per IEEE 1149.1 on TCK rise using TMS; five TMS=1 clocks reach TLR from any state.
- IR shift register: CapIR loads {0…0,01}; ShIR shifts right, TDI into MSB, LSB toward TDO.
- instr loads from IR shift register on TCK fall in UpdIR; set to OP_IDCODE on TCK fall in TLR.
- Decode: EXTEST and SAMPLE select BSR (bsr_tdo); IDCODE selects 32-bit IDCODE reg; BYPASS and any undefined opcode select 1-bit bypass reg.
- IDCODE reg: CapDR loads IDCODE_VAL; ShDR shifts right, TDI into bit 31. Bypass reg: CapDR loads 0; ShDR loads TDI. Unselected DRs hold.
- clockdr = CapDR or ShDR; clockir = CapIR or ShIR; shift*/update* decode state directly.
- bs_en = (instr == OP_EXTEST); purely from instr, independent of state.
- select = 1 in SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR; else 0.

## Timing
- TRST low: state = TLR, instr = OP_IDCODE, IR shift reg = {0…0,01}, IDCODE reg = IDCODE_VAL, bypass = 0, TDO = 0, tdo_en = 0, bs_en = 0, select = 0, all shift/clock/update outputs 0. Mid-shift reset aborts immediately; no instr update.
- TMS/TDI sampled on TCK rise; state, shift registers update on rise.
- TDO and tdo_en registered on TCK fall: in ShIR, TDO = IR LSB; in ShDR, TDO = LSB of selected DR; tdo_en = 1 only in ShIR/ShDR; otherwise TDO = 0, tdo_en = 0.
- First TDO bit in a shift is the captured LSB, valid from the fall after entering ShIR/ShDR.
- Bypass path latency TDI→TDO: one TCK cycle.
- instr changes only on the fall in UpdIR/TLR, so bs_en never glitches during ShIR.
- Ex1/Pause/Ex2 hold all shift registers.

## Test plan
- TRST pulse low then high, TMS=1 → state F, instr 4'b0010, TDO 0, tdo_en 0, bs_en 0.
- From PauseIR, TMS=1 for 5 TCKs → state F, instr returns to IDCODE.
- Load IR: TLR→RTI→SelDR→SelIR→CapIR→ShIR, shift 4'b1111 → TDO emits 1,0,0,0 (captured 0001 LSB first); after UpdIR instr = 4'b1111.
- After reset, go to ShDR, shift 32 bits → TDO streams 32'h1000_0001 LSB first; bit 0 = 1.
- BYPASS: shift 8'hA5 through ShDR → TDO replays 0 then A5 bits with one-cycle delay.
- Load OP_EXTEST → bs_en rises on UpdIR fall; in ShDR TDO follows bsr_tdo; clockdr high in CapDR/ShDR; load OP_SAMPLE → bs_en 0.
